// File: rtl/vi_crc_emr_seq_if.sv
// Bus between the CRC EMR sequencer and its surroundings: the crcblock atom
// (crc_error, ed_regout, ed_clk, ed_shiftnld) and the CSR/status logic
// (emr_req, emr, emr_valid, busy, crc_error_event, err_count, miss_count).
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface vi_crc_emr_seq_if #(
  parameter int EMR_WIDTH = 67
);
  logic                 crc_error;
  logic                 ed_regout;
  logic                 emr_req;
  logic                 ed_clk;
  logic                 ed_shiftnld;
  logic [EMR_WIDTH-1:0] emr;
  logic                 emr_valid;
  logic                 busy;
  logic                 crc_error_event;
  logic [15:0]          err_count;
  logic [7:0]           miss_count;

  modport master (
    output crc_error, ed_regout, emr_req,
    input  ed_clk, ed_shiftnld, emr, emr_valid, busy,
           crc_error_event, err_count, miss_count
  );

  modport slave (
    input  crc_error, ed_regout, emr_req,
    output ed_clk, ed_shiftnld, emr, emr_valid, busy,
           crc_error_event, err_count, miss_count
  );
endinterface

// File: rtl/vi_crc_emr_seq.sv
// vi_crc_emr_seq: sequencer for the Stratix V crcblock user shift register.
// On a synchronized CRC error (or an explicit emr_req) it parallel-loads the
// error message register inside the atom, shifts EMR_WIDTH bits out through a
// generated ED clock, and presents the assembled EMR with a one-cycle valid.
// Optional feature macro: VI_CRC_EMR_MISS_CNT_EN builds a saturating counter
// of errors that arrive while a sequence is already in progress; without it
// miss_count is tied to zero.
module vi_crc_emr_seq #(
  parameter int EMR_WIDTH = 67,
  parameter int CLK_DIV   = 2
) (
  input logic             clk,
  input logic             rst_n,
  vi_crc_emr_seq_if.slave bus
);

  localparam int CNT_W = $clog2(4 * CLK_DIV + 1);
  localparam int BIT_W = (EMR_WIDTH > 1) ? $clog2(EMR_WIDTH) : 1;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(4 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(EMR_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WAIT,
    LOAD_CLK,
    SHIFT,
    DONE,
    REARM
  } state_t;

  state_t               state;
  logic                 sync_s1;
  logic                 sync_s2;
  logic                 sync_r;
  logic                 err_evt;
  logic                 evt_q;
  logic [15:0]          err_cnt_q;
  logic [CNT_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [EMR_WIDTH-1:0] shadow;
  logic [EMR_WIDTH-1:0] emr_q;
  logic                 emr_valid_q;
  logic                 busy_q;
  logic                 ed_clk_q;
  logic                 ed_shiftnld_q;

  assign err_evt = sync_s2 & ~sync_r;

  // Bring crc_error into the clk domain and register its rising edge as an event pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1 <= 1'b0;
      sync_s2 <= 1'b0;
      sync_r  <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      sync_s1 <= bus.crc_error;
      sync_s2 <= sync_s1;
      sync_r  <= sync_s2;
      evt_q   <= err_evt;
    end
  end

  // Count every error event regardless of sequencer state, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (err_evt && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  // Load/shift sequencer: generates the ED clock and shiftnld from flops and assembles the EMR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      shadow        <= '0;
      emr_q         <= '0;
      emr_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      ed_clk_q      <= 1'b1;
      ed_shiftnld_q <= 1'b1;
    end else begin
      emr_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (err_evt || bus.emr_req) begin
            state         <= LOAD_WAIT;
            busy_q        <= 1'b1;
            ed_shiftnld_q <= 1'b0;
            ed_clk_q      <= 1'b1;
            div_cnt       <= '0;
          end
        end
        LOAD_WAIT: begin
          if (div_cnt == WAIT_LAST) begin
            state    <= LOAD_CLK;
            ed_clk_q <= 1'b0;
            div_cnt  <= '0;
          end else begin
            div_cnt <= div_cnt + CNT_ONE;
          end
        end
        LOAD_CLK: begin
          if (div_cnt == FULL_LAST) begin
            state         <= SHIFT;
            ed_shiftnld_q <= 1'b1;
            div_cnt       <= '0;
            bit_cnt       <= '0;
          end else begin
            if (div_cnt == HALF_LAST) begin
              ed_clk_q <= 1'b1;
            end
            div_cnt <= div_cnt + CNT_ONE;
          end
        end
        SHIFT: begin
          if (div_cnt == FULL_LAST) begin
            ed_clk_q <= 1'b1;
            div_cnt  <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= DONE;
            end else begin
              bit_cnt <= bit_cnt + BIT_ONE;
            end
          end else begin
            if (div_cnt == HALF_LAST) begin
              shadow[bit_cnt] <= bus.ed_regout;
              ed_clk_q        <= 1'b0;
            end
            div_cnt <= div_cnt + CNT_ONE;
          end
        end
        DONE: begin
          emr_q       <= shadow;
          emr_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= sync_s2 ? REARM : IDLE;
        end
        REARM: begin
          if (bus.emr_req) begin
            state         <= LOAD_WAIT;
            busy_q        <= 1'b1;
            ed_shiftnld_q <= 1'b0;
            ed_clk_q      <= 1'b1;
            div_cnt       <= '0;
          end else if (!sync_s2) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef VI_CRC_EMR_MISS_CNT_EN
  logic [7:0] miss_cnt_q;

  // Count errors that land while a sequence is already running, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= '0;
    end else if (err_evt && (state != IDLE) && (miss_cnt_q != 8'hFF)) begin
      miss_cnt_q <= miss_cnt_q + 8'd1;
    end
  end

  assign bus.miss_count = miss_cnt_q;
`else
  assign bus.miss_count = 8'h00;
`endif

  assign bus.ed_clk          = ed_clk_q;
  assign bus.ed_shiftnld     = ed_shiftnld_q;
  assign bus.emr             = emr_q;
  assign bus.emr_valid       = emr_valid_q;
  assign bus.busy            = busy_q;
  assign bus.crc_error_event = evt_q;
  assign bus.err_count       = err_cnt_q;

endmodule

// File: tb/tb_vi_crc_emr_seq.sv
// Testbench for vi_crc_emr_seq. Three instances (CLK_DIV = 2, 1, 16) each
// talk to a behavioural model of the crcblock user shift register. Expected
// values come from the described behaviour: the EMR read back equals the value
// loaded into the atom model, emr_valid lands at N+2+(6+2*W)*D+1, and the
// error counter equals the number of crc_error rising edges applied.
module tb_vi_crc_emr_seq;

  localparam int W = 67;

`ifdef VI_CRC_EMR_MISS_CNT_EN
  localparam int MISS_PER_OVERLAP = 1;
`else
  localparam int MISS_PER_OVERLAP = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic         crc_err  [3];
  logic         req      [3];
  logic [W-1:0] atom_val [3];
  int           exp_err  [3];
  int           div_of   [3];
  int           exp_miss = 0;
  int           sel      = 0;

  logic [W-1:0] sr_a = '0;
  logic [W-1:0] sr_b = '0;
  logic [W-1:0] sr_c = '0;

  // selected-instance view
  logic         m_clk;
  logic         m_sh;
  logic         m_valid;
  logic         m_evt;
  logic         m_busy;
  logic [W-1:0] m_emr;
  logic [15:0]  m_err;
  logic [7:0]   m_miss;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  vi_crc_emr_seq_if #(.EMR_WIDTH(W)) bus_a ();
  vi_crc_emr_seq_if #(.EMR_WIDTH(W)) bus_b ();
  vi_crc_emr_seq_if #(.EMR_WIDTH(W)) bus_c ();

  vi_crc_emr_seq #(.EMR_WIDTH(W), .CLK_DIV(2))  dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  vi_crc_emr_seq #(.EMR_WIDTH(W), .CLK_DIV(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  vi_crc_emr_seq #(.EMR_WIDTH(W), .CLK_DIV(16)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  assign bus_a.crc_error = crc_err[0];
  assign bus_b.crc_error = crc_err[1];
  assign bus_c.crc_error = crc_err[2];
  assign bus_a.emr_req   = req[0];
  assign bus_b.emr_req   = req[1];
  assign bus_c.emr_req   = req[2];
  assign bus_a.ed_regout = sr_a[0];
  assign bus_b.ed_regout = sr_b[0];
  assign bus_c.ed_regout = sr_c[0];

  // Atom models: load on ED clock fall with shiftnld low, shift toward bit 0 otherwise
  always @(negedge bus_a.ed_clk) sr_a <= bus_a.ed_shiftnld ? (sr_a >> 1) : atom_val[0];
  always @(negedge bus_b.ed_clk) sr_b <= bus_b.ed_shiftnld ? (sr_b >> 1) : atom_val[1];
  always @(negedge bus_c.ed_clk) sr_c <= bus_c.ed_shiftnld ? (sr_c >> 1) : atom_val[2];

  // Route the instance under test to one set of observation signals
  always_comb begin
    case (sel)
      1: begin
        m_clk = bus_b.ed_clk; m_sh = bus_b.ed_shiftnld; m_valid = bus_b.emr_valid;
        m_evt = bus_b.crc_error_event; m_busy = bus_b.busy; m_emr = bus_b.emr;
        m_err = bus_b.err_count; m_miss = bus_b.miss_count;
      end
      2: begin
        m_clk = bus_c.ed_clk; m_sh = bus_c.ed_shiftnld; m_valid = bus_c.emr_valid;
        m_evt = bus_c.crc_error_event; m_busy = bus_c.busy; m_emr = bus_c.emr;
        m_err = bus_c.err_count; m_miss = bus_c.miss_count;
      end
      default: begin
        m_clk = bus_a.ed_clk; m_sh = bus_a.ed_shiftnld; m_valid = bus_a.emr_valid;
        m_evt = bus_a.crc_error_event; m_busy = bus_a.busy; m_emr = bus_a.emr;
        m_err = bus_a.err_count; m_miss = bus_a.miss_count;
      end
    endcase
  end

  function automatic logic [W-1:0] rand_val();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      crc_err[k] = 1'b0;
      req[k]     = 1'b0;
      exp_err[k] = 0;
    end
    exp_miss = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      tests_run++;
      if (m_clk !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL reset_ed_clk[%0d]: got %b expected 1", k, m_clk);
      end
      tests_run++;
      if (m_sh !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL reset_shiftnld[%0d]: got %b expected 1", k, m_sh);
      end
      tests_run++;
      if (m_emr !== '0) begin
        tests_failed++; $display("[TB] FAIL reset_emr[%0d]: got %h expected 0", k, m_emr);
      end
      tests_run++;
      if (m_err !== 16'd0) begin
        tests_failed++; $display("[TB] FAIL reset_err_count[%0d]: got %0d expected 0", k, m_err);
      end
      tests_run++;
      if (m_busy !== 1'b0 || m_valid !== 1'b0 || m_miss !== 8'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_status[%0d]: got busy=%b valid=%b miss=%0d expected 0/0/0",
                 k, m_busy, m_valid, m_miss);
      end
    end
    sel = 0;
    @(negedge clk);
  endtask

  task automatic test_error_read(input int s, input logic [W-1:0] val, input bit keep_high);
    int d, n, exp_lat, evt_at, val_at, nvalid, nevt, zeros, low_run, first_low;
    sel = s;
    d = div_of[s];
    atom_val[s] = val;
    exp_lat = 2 + (6 + 2 * W) * d + 1;
    repeat ($urandom_range(1, 20)) @(negedge clk);
    crc_err[s] = 1'b1;
    n = cyc + 1;
    exp_err[s] = exp_err[s] + 1;
    evt_at = -1; val_at = -1; nvalid = 0; nevt = 0; zeros = 0; low_run = 0; first_low = -1;
    for (int i = 0; i < exp_lat + 40 && val_at < 0; i++) begin
      @(negedge clk);
      if (m_evt) begin
        nevt++;
        if (evt_at < 0) evt_at = cyc;
      end
      if (m_valid) begin
        nvalid++;
        val_at = cyc;
      end
      if (!m_sh) zeros++;
      if (m_sh && !m_clk) low_run++;
      else begin
        if (low_run > 0 && first_low < 0) first_low = low_run;
        low_run = 0;
      end
    end
    repeat (5) begin
      @(negedge clk);
      if (m_valid) nvalid++;
      if (m_evt) nevt++;
    end
    tests_run++;
    if (val_at < 0) begin
      tests_failed++; $display("[TB] FAIL read_timeout[%0d]: got no emr_valid expected one within %0d cycles", s, exp_lat + 40);
    end
    tests_run++;
    if (evt_at != n + 2) begin
      tests_failed++; $display("[TB] FAIL event_latency[%0d]: got cycle %0d expected %0d", s, evt_at, n + 2);
    end
    tests_run++;
    if (val_at != n + exp_lat) begin
      tests_failed++; $display("[TB] FAIL valid_latency[%0d]: got cycle %0d expected %0d", s, val_at, n + exp_lat);
    end
    tests_run++;
    if (m_emr !== val) begin
      tests_failed++; $display("[TB] FAIL emr_value[%0d]: got %h expected %h", s, m_emr, val);
    end
    tests_run++;
    if (m_err !== 16'(exp_err[s])) begin
      tests_failed++; $display("[TB] FAIL err_count[%0d]: got %0d expected %0d", s, m_err, exp_err[s]);
    end
    tests_run++;
    if (zeros != 6 * d) begin
      tests_failed++; $display("[TB] FAIL load_cycles[%0d]: got %0d expected %0d", s, zeros, 6 * d);
    end
    tests_run++;
    if (first_low != d) begin
      tests_failed++; $display("[TB] FAIL ed_half_period[%0d]: got %0d expected %0d", s, first_low, d);
    end
    tests_run++;
    if (nvalid != 1 || nevt != 1) begin
      tests_failed++; $display("[TB] FAIL pulse_counts[%0d]: got valid=%0d event=%0d expected 1/1", s, nvalid, nevt);
    end
    tests_run++;
    if (m_busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL busy_after_done[%0d]: got %b expected 0", s, m_busy);
    end
    if (!keep_high) begin
      crc_err[s] = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic test_rearm();
    logic [W-1:0] val;
    int nevt, start, val_at, exp_at;
    sel = 0;
    val = rand_val();
    atom_val[0] = val;
    nevt = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_evt) nevt++;
    end
    tests_run++;
    if (m_busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL rearm_busy: got %b expected 0", m_busy);
    end
    req[0] = 1'b1;
    start = cyc + 1;
    @(negedge clk);
    req[0] = 1'b0;
    exp_at = start + (6 + 2 * W) * div_of[0] + 1;
    val_at = -1;
    for (int i = 0; i < (6 + 2 * W) * div_of[0] + 40 && val_at < 0; i++) begin
      @(negedge clk);
      if (m_evt) nevt++;
      if (m_valid) val_at = cyc;
    end
    tests_run++;
    if (val_at != exp_at) begin
      tests_failed++; $display("[TB] FAIL rearm_valid_at: got cycle %0d expected %0d", val_at, exp_at);
    end
    tests_run++;
    if (m_emr !== val) begin
      tests_failed++; $display("[TB] FAIL rearm_emr: got %h expected %h", m_emr, val);
    end
    tests_run++;
    if (m_err !== 16'(exp_err[0]) || nevt != 0) begin
      tests_failed++; $display("[TB] FAIL rearm_no_count: got count=%0d events=%0d expected %0d/0", m_err, nevt, exp_err[0]);
    end
    crc_err[0] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_miss();
    logic [W-1:0] val;
    int nvalid, busy_after, val_at, phase;
    sel = 0;
    val = rand_val();
    atom_val[0] = val;
    @(negedge clk);
    crc_err[0] = 1'b1;
    exp_err[0] = exp_err[0] + 1;
    phase = 0;
    for (int i = 0; i < 200 && phase < 20; i++) begin
      @(negedge clk);
      if (phase == 0 && !m_sh) phase = 1;
      else if (phase >= 1 && m_sh && m_busy) phase++;
    end
    crc_err[0] = 1'b0;
    repeat (4) @(negedge clk);
    crc_err[0] = 1'b1;
    exp_err[0] = exp_err[0] + 1;
    exp_miss = exp_miss + MISS_PER_OVERLAP;
    nvalid = 0; val_at = -1; busy_after = 0;
    for (int i = 0; i < 400 && val_at < 0; i++) begin
      @(negedge clk);
      if (m_valid) begin
        nvalid++;
        val_at = cyc;
      end
    end
    repeat (60) begin
      @(negedge clk);
      if (m_valid) nvalid++;
      if (m_busy) busy_after++;
    end
    tests_run++;
    if (val_at < 0 || m_emr !== val) begin
      tests_failed++; $display("[TB] FAIL miss_emr: got %h expected %h", m_emr, val);
    end
    tests_run++;
    if (m_err !== 16'(exp_err[0])) begin
      tests_failed++; $display("[TB] FAIL miss_err_count: got %0d expected %0d", m_err, exp_err[0]);
    end
    tests_run++;
    if (nvalid != 1 || busy_after != 0) begin
      tests_failed++; $display("[TB] FAIL miss_no_restart: got valid=%0d busy_cycles=%0d expected 1/0", nvalid, busy_after);
    end
    tests_run++;
    if (m_miss !== 8'(exp_miss)) begin
      tests_failed++; $display("[TB] FAIL miss_count: got %0d expected %0d", m_miss, exp_miss);
    end
    crc_err[0] = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int falls;
    logic prev_clk;
    sel = 0;
    atom_val[0] = rand_val();
    @(negedge clk);
    crc_err[0] = 1'b1;
    falls = 0;
    prev_clk = 1'b1;
    for (int i = 0; i < 600 && falls < 30; i++) begin
      @(negedge clk);
      if (m_sh && m_busy && prev_clk && !m_clk) falls++;
      prev_clk = m_clk;
    end
    tests_run++;
    if (falls != 30) begin
      tests_failed++; $display("[TB] FAIL midreset_reach: got %0d shift clocks expected 30", falls);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (m_clk !== 1'b1 || m_sh !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL midreset_ed: got ed_clk=%b shiftnld=%b expected 1/1", m_clk, m_sh);
    end
    tests_run++;
    if (m_emr !== '0 || m_busy !== 1'b0 || m_err !== 16'd0) begin
      tests_failed++; $display("[TB] FAIL midreset_state: got emr=%h busy=%b count=%0d expected 0/0/0", m_emr, m_busy, m_err);
    end
    crc_err[0] = 1'b0;
    for (int k = 0; k < 3; k++) exp_err[k] = 0;
    exp_miss = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 100000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] first_val;
    div_of[0] = 2;
    div_of[1] = 1;
    div_of[2] = 16;
    for (int k = 0; k < 3; k++) begin
      crc_err[k]  = 1'b0;
      req[k]      = 1'b0;
      atom_val[k] = '0;
      exp_err[k]  = 0;
    end
    first_val = {3'b101, 64'hA5A5_0000_1234_C0DE};
    test_reset();
    test_error_read(0, first_val, 1'b1);
    test_rearm();
    test_miss();
    test_reset_mid();
    test_error_read(0, rand_val(), 1'b0);
    test_error_read(1, rand_val(), 1'b0);
    test_error_read(2, rand_val(), 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
